// File: rtl/ysyx_22040386_hz_pkg.sv
// Shared types and helpers for the ysyx_22040386 hazard/forwarding scoreboard.
package ysyx_22040386_hz_pkg;

    // Widest register address a record can carry; narrower addresses are zero-extended.
    localparam int HZ_RD_W     = 8;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic               load;
        logic               rdy;
        logic [HZ_RD_W-1:0] rd;
    } hz_rec_t;

    function automatic int hz_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ysyx_22040386_hz_lookup.sv
// Priority match of one source register against the in-flight destination records.
module ysyx_22040386_hz_lookup
    import ysyx_22040386_hz_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int NREG_W = 5
) (
    input  hz_rec_t [DEPTH-1:0]                  recs,
    input  logic    [NREG_W-1:0]                 rs,
    input  logic                                 use_rs,
    output logic    [hz_sel_w(DEPTH)-1:0]        sel,
    output logic                                 hazard
);

    localparam int SEL_W = hz_sel_w(DEPTH);

    // Scan oldest to youngest so the youngest matching producer is written last.
    always_comb begin
        sel    = SEL_W'(FWD_REGFILE);
        hazard = 1'b0;
        if (use_rs && rs != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (recs[k].valid && recs[k].we && recs[k].rd == HZ_RD_W'(rs)) begin
                    sel    = recs[k].rdy ? SEL_W'(k + 1) : SEL_W'(FWD_REGFILE);
                    hazard = !recs[k].rdy;
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22040386_hazard_ctrl.sv
// Scoreboard-based hazard and forwarding controller: tracks DEPTH post-decode
// destination records, resolves forwarding, load-use stalls, hold and redirect.
module ysyx_22040386_hazard_ctrl
    import ysyx_22040386_hz_pkg::*;
#(
    parameter int DEPTH          = 3,
    parameter int NREG_W         = 5,
    parameter int LOAD_RDY_STAGE = 2,
    parameter int FLUSH_STAGE    = 2,
    parameter int CNT_W          = 32
) (
    input  logic                       i_HZ_clk,
    input  logic                       i_HZ_rst,
    input  logic                       i_HZ_issue_valid,
    input  logic                       i_HZ_issue_we,
    input  logic                       i_HZ_issue_load,
    input  logic [NREG_W-1:0]          i_HZ_issue_rd,
    input  logic [NREG_W-1:0]          i_HZ_rs1,
    input  logic [NREG_W-1:0]          i_HZ_rs2,
    input  logic                       i_HZ_use_rs1,
    input  logic                       i_HZ_use_rs2,
    input  logic                       i_HZ_hold,
    input  logic                       i_HZ_flush,
    output logic                       o_HZ_issue_ready,
    output logic                       o_HZ_load_use,
    output logic [hz_sel_w(DEPTH)-1:0] o_HZ_fwd_sel1,
    output logic [hz_sel_w(DEPTH)-1:0] o_HZ_fwd_sel2,
    output logic [DEPTH-1:0]           o_HZ_stg_valid,
    output logic [CNT_W-1:0]           o_HZ_stall_cnt,
    output logic [CNT_W-1:0]           o_HZ_flush_cnt
);

    hz_rec_t [DEPTH-1:0] recs;
    hz_rec_t [DEPTH-1:0] next_recs;
    logic                hazard1;
    logic                hazard2;
    logic                accept;

    ysyx_22040386_hz_lookup #(.DEPTH(DEPTH), .NREG_W(NREG_W)) u_lookup1 (
        .recs   (recs),
        .rs     (i_HZ_rs1),
        .use_rs (i_HZ_use_rs1),
        .sel    (o_HZ_fwd_sel1),
        .hazard (hazard1)
    );

    ysyx_22040386_hz_lookup #(.DEPTH(DEPTH), .NREG_W(NREG_W)) u_lookup2 (
        .recs   (recs),
        .rs     (i_HZ_rs2),
        .use_rs (i_HZ_use_rs2),
        .sel    (o_HZ_fwd_sel2),
        .hazard (hazard2)
    );

    assign o_HZ_load_use    = i_HZ_issue_valid & (hazard1 | hazard2);
    assign o_HZ_issue_ready = !o_HZ_load_use & !i_HZ_hold & !i_HZ_flush;
    assign accept           = i_HZ_issue_valid & o_HZ_issue_ready;

    // NOTE: next_recs gets a full default first so no path through this block infers a latch.
    always_comb begin
        next_recs = recs;
        if (i_HZ_hold) begin
            if (i_HZ_flush) begin
                for (int k = 0; k < FLUSH_STAGE; k++) begin
                    next_recs[k].valid = 1'b0;
                end
            end
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                next_recs[k]     = recs[k-1];
                next_recs[k].rdy = recs[k-1].rdy | (k >= LOAD_RDY_STAGE);
                // Younger than the redirecting instruction: squash.
                if (i_HZ_flush && k <= FLUSH_STAGE) begin
                    next_recs[k] = '0;
                end
            end
            next_recs[0] = '0;
            if (accept) begin
                next_recs[0].valid = 1'b1;
                next_recs[0].we    = i_HZ_issue_we;
                next_recs[0].load  = i_HZ_issue_load;
                next_recs[0].rdy   = !i_HZ_issue_load | (LOAD_RDY_STAGE == 0);
                next_recs[0].rd    = HZ_RD_W'(i_HZ_issue_rd);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; every record is reset
    // because stale valid bits would create phantom hazards after reset.
    always_ff @(posedge i_HZ_clk or posedge i_HZ_rst) begin
        if (i_HZ_rst) begin
            recs           <= '0;
            o_HZ_stall_cnt <= '0;
            o_HZ_flush_cnt <= '0;
        end else begin
            recs <= next_recs;
            if (i_HZ_issue_valid && !o_HZ_issue_ready && o_HZ_stall_cnt != '1) begin
                o_HZ_stall_cnt <= o_HZ_stall_cnt + CNT_W'(1);
            end
            if (i_HZ_flush && o_HZ_flush_cnt != '1) begin
                o_HZ_flush_cnt <= o_HZ_flush_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_HZ_stg_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_HZ_stg_valid[k] = recs[k].valid;
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_hazard_ctrl.sv
// Directed bench for ysyx_22040386_hazard_ctrl: default instance plus a DEPTH=4, CNT_W=4 instance.
module tb_ysyx_22040386_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_we, issue_load;
    logic [4:0] issue_rd, rs1, rs2;
    logic       use_rs1, use_rs2, hold, flush;

    logic       issue_ready, load_use;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic [2:0] stg_valid;
    logic [31:0] stall_cnt, flush_cnt;

    logic       issue_ready4, load_use4;
    logic [2:0] fwd_sel14, fwd_sel24;
    logic [3:0] stg_valid4;
    logic [3:0] stall_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22040386_hazard_ctrl dut (
        .i_HZ_clk(clk), .i_HZ_rst(rst),
        .i_HZ_issue_valid(issue_valid), .i_HZ_issue_we(issue_we),
        .i_HZ_issue_load(issue_load), .i_HZ_issue_rd(issue_rd),
        .i_HZ_rs1(rs1), .i_HZ_rs2(rs2),
        .i_HZ_use_rs1(use_rs1), .i_HZ_use_rs2(use_rs2),
        .i_HZ_hold(hold), .i_HZ_flush(flush),
        .o_HZ_issue_ready(issue_ready), .o_HZ_load_use(load_use),
        .o_HZ_fwd_sel1(fwd_sel1), .o_HZ_fwd_sel2(fwd_sel2),
        .o_HZ_stg_valid(stg_valid),
        .o_HZ_stall_cnt(stall_cnt), .o_HZ_flush_cnt(flush_cnt)
    );

    ysyx_22040386_hazard_ctrl #(.DEPTH(4), .FLUSH_STAGE(2), .CNT_W(4)) dut4 (
        .i_HZ_clk(clk), .i_HZ_rst(rst),
        .i_HZ_issue_valid(issue_valid), .i_HZ_issue_we(issue_we),
        .i_HZ_issue_load(issue_load), .i_HZ_issue_rd(issue_rd),
        .i_HZ_rs1(rs1), .i_HZ_rs2(rs2),
        .i_HZ_use_rs1(use_rs1), .i_HZ_use_rs2(use_rs2),
        .i_HZ_hold(hold), .i_HZ_flush(flush),
        .o_HZ_issue_ready(issue_ready4), .o_HZ_load_use(load_use4),
        .o_HZ_fwd_sel1(fwd_sel14), .o_HZ_fwd_sel2(fwd_sel24),
        .o_HZ_stg_valid(stg_valid4),
        .o_HZ_stall_cnt(stall_cnt4), .o_HZ_flush_cnt(flush_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2);
        issue_valid = v;  issue_we = we; issue_load = ld; issue_rd = rd;
        rs1 = s1; rs2 = s2; use_rs1 = u1; use_rs2 = u2;
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst_stg_valid", stg_valid, 3'b000);
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_load_use", load_use, 1'b0);
        check("rst_fwd_sel1", fwd_sel1, 2'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        #5 rst = 1'b0;

        // add x5, then readers of x5 one and two cycles later
        drive(1, 1, 0, 5, 0, 0, 0, 0); #2;
        check("add_x5_ready", issue_ready, 1'b1);
        tick();
        drive(1, 1, 0, 6, 5, 0, 1, 0); #2;
        check("fwd_ex_ready", issue_ready, 1'b1);
        check("fwd_ex_sel1", fwd_sel1, 2'd1);
        tick();
        drive(1, 1, 0, 10, 5, 0, 1, 0); #2;
        check("fwd_mem_sel1", fwd_sel1, 2'd2);
        tick();

        // ld x7, independent store, then reader of x7: one stall cycle
        drive(1, 1, 1, 7, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 8, 7, 0, 1, 0); #2;
        check("ldu_load_use", load_use, 1'b1);
        check("ldu_ready", issue_ready, 1'b0);
        tick(); #2;
        check("ldu_after_load_use", load_use, 1'b0);
        check("ldu_after_ready", issue_ready, 1'b1);
        check("ldu_after_sel1", fwd_sel1, 2'd3);
        check("ldu_stall_cnt", stall_cnt, 32'd1);
        check("ldu_stg_valid", stg_valid, 3'b110);
        tick();

        // Two writers of x9 in stages 0 and 2; x0 writer then reader of x0
        drive(1, 1, 0, 9, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 11, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 9, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 9, 9, 1, 1); #2;
        check("youngest_sel1", fwd_sel1, 2'd1);
        check("youngest_sel2", fwd_sel2, 2'd1);
        tick();
        drive(0, 0, 0, 0, 0, 9, 1, 1); #2;
        check("x0_sel1", fwd_sel1, 2'd0);
        check("x9_stage1_sel2", fwd_sel2, 2'd2);
        tick();

        // ld x12 in stage 1, then a 3-cycle memory hold with a valid issue
        drive(1, 1, 1, 12, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("hold_ready", issue_ready, 1'b0);
            check("hold_stg_valid", stg_valid, 3'b011);
            tick();
        end
        hold = 1'b0;
        drive(0, 0, 0, 0, 12, 0, 1, 0); #2;
        check("hold_stall_cnt", stall_cnt, 32'd4);
        check("hold_after_stg", stg_valid, 3'b011);
        check("invalid_issue_no_load_use", load_use, 1'b0);
        tick();
        drive(1, 1, 0, 13, 12, 0, 1, 0); #2;
        check("ld_wb_sel1", fwd_sel1, 2'd3);
        check("ld_wb_stg", stg_valid, 3'b110);
        tick();
        drive(1, 1, 0, 14, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 15, 0, 0, 0, 0); tick();

        // Flush during hold: stages below FLUSH_STAGE invalidated in place
        check("pre_hflush_stg", stg_valid, 3'b111);
        hold = 1'b1; flush = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("hflush_ready", issue_ready, 1'b0);
        tick();
        hold = 1'b0; flush = 1'b0;
        check("hflush_stg", stg_valid, 3'b100);
        check("hflush_cnt", flush_cnt, 32'd1);
        check("hflush_stall_cnt", stall_cnt, 32'd4);

        // Asynchronous reset mid-stream
        drive(1, 1, 0, 16, 0, 0, 0, 0); tick();
        check("pre_rst_stg", stg_valid, 3'b001);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_stg", stg_valid, 3'b000);
        check("mid_rst_stall", stall_cnt, 32'd0);
        check("mid_rst_flush", flush_cnt, 32'd0);
        check("mid_rst_stg4", stg_valid4, 4'b0000);
        #2 rst = 1'b0;

        // Flush without hold, DEPTH=3 and DEPTH=4 instances side by side
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("pre_flush_stg", stg_valid, 3'b111);
        check("pre_flush_stg4", stg_valid4, 4'b0111);
        flush = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("flush_ready", issue_ready, 1'b0);
        tick();
        flush = 1'b0;
        check("flush_stg", stg_valid, 3'b000);
        check("flush_stg4", stg_valid4, 4'b1000);
        check("flush_cnt", flush_cnt, 32'd1);
        check("flush_cnt4", flush_cnt4, 4'd1);

        // 20 held cycles with a valid issue: 4-bit counter saturates
        hold = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall_cnt", stall_cnt, 32'd20);
        check("sat_stall_cnt4", stall_cnt4, 4'd15);
        check("sat_stg4", stg_valid4, 4'b1000);
        hold = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
